// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between IFU (read-only) and LSU.
// Define MEM_ARB_PERF_EN to add saturating grant/stall performance counters.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_ifu_cnt,
  output logic [31:0]       perf_lsu_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        r_state;
  logic              r_last_grant;  // 0 = IFU, 1 = LSU
  logic              r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic [7:0]        r_wmask;
  logic [DATA_W-1:0] r_ifu_rdata;
  logic [DATA_W-1:0] r_lsu_rdata;

  logic w_idle;
  logic w_grant_ifu;
  logic w_grant_lsu;

  // Gating with rst keeps the ready outputs low while reset is asserted.
  assign w_idle      = rst && (r_state == S_IDLE);
  assign w_grant_ifu = w_idle && ifu_req_valid && (!lsu_req_valid || r_last_grant);
  assign w_grant_lsu = w_idle && lsu_req_valid && (!ifu_req_valid || !r_last_grant);

  assign ifu_req_ready  = w_grant_ifu;
  assign lsu_req_ready  = w_grant_lsu;
  assign mem_req_valid  = (r_state == S_ISSUE);
  assign mem_addr       = r_addr;
  assign mem_wen        = r_wen;
  assign mem_wdata      = r_wdata;
  assign mem_wmask      = r_wmask;
  assign ifu_resp_valid = (r_state == S_RESP) && !r_owner;
  assign lsu_resp_valid = (r_state == S_RESP) && r_owner;
  assign ifu_rdata      = r_ifu_rdata;
  assign lsu_rdata      = r_lsu_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_addr       <= '0;
      r_wen        <= 1'b0;
      r_wdata      <= '0;
      r_wmask      <= 8'h00;
      r_ifu_rdata  <= '0;
      r_lsu_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_ifu) begin
            r_addr       <= ifu_addr;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_wmask      <= 8'h00;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b0;
            r_state      <= S_ISSUE;
          end else if (w_grant_lsu) begin
            r_addr       <= lsu_addr;
            r_wen        <= lsu_wen;
            r_wdata      <= lsu_wdata;
            r_wmask      <= lsu_wen ? lsu_wmask : 8'h00;
            r_owner      <= 1'b1;
            r_last_grant <= 1'b1;
            r_state      <= S_ISSUE;
          end else begin
            r_state      <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (mem_req_ready) begin
            r_state <= S_WAIT;
          end else begin
            r_state <= S_ISSUE;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            // Writes report zero data; the other requester's last data is left untouched.
            if (r_owner) begin
              r_lsu_rdata <= r_wen ? '0 : mem_rdata;
            end else begin
              r_ifu_rdata <= mem_rdata;
            end
            r_state <= S_RESP;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic w_stall;
  assign w_stall = (ifu_req_valid || lsu_req_valid) && !(w_grant_ifu || w_grant_lsu);

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_ifu_cnt   <= 32'd0;
      perf_lsu_cnt   <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else begin
      if (w_grant_ifu && (perf_ifu_cnt != 32'hFFFF_FFFF)) begin
        perf_ifu_cnt <= perf_ifu_cnt + 32'd1;
      end
      if (w_grant_lsu && (perf_lsu_cnt != 32'hFFFF_FFFF)) begin
        perf_lsu_cnt <= perf_lsu_cnt + 32'd1;
      end
      if (w_stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_arbiter;
  logic        clk;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_ifu_cnt, perf_lsu_cnt, perf_stall_cnt;
`endif

  int          total = 0;
  int          bad = 0;
  int          n_ifu = 0;
  int          n_lsu = 0;
  logic [31:0] phys [16];
  logic [31:0] refm [16];
  logic        resp_en;
  logic        late_resp;
  logic        model_last;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
    , .perf_ifu_cnt(perf_ifu_cnt), .perf_lsu_cnt(perf_lsu_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: memory side samples the handshake at the edge and answers one cycle after accept.
  task automatic tick();
    logic        hs;
    logic        w;
    logic [31:0] d;
    logic [7:0]  m;
    int          idx;
    @(posedge clk);
    hs  = mem_req_valid && mem_req_ready;
    w   = mem_wen;
    d   = mem_wdata;
    m   = mem_wmask;
    idx = int'(mem_addr[5:2]);
    if (hs && w) begin
      for (int b = 0; b < 4; b++) if (m[b]) phys[idx][8*b +: 8] = d[8*b +: 8];
    end
    #1;
    mem_resp_valid = (hs && resp_en) || late_resp;
    mem_rdata      = (hs && !w) ? phys[idx] : $urandom;
  endtask

  // Runs one full transaction, checking every phase; returns which requester was granted.
  task automatic serve(input int stall, output logic own);
    int          n;
    int          idx;
    logic [31:0] a, wd, expd;
    logic        w;
    logic [7:0]  m;
    n = 0;
    #1;
    while (!(ifu_req_ready || lsu_req_ready) && n < 8) begin
      tick();
      #1;
      n++;
    end
    chk("grant_seen", 64'(n < 8), 64'd1);
    chk("single_ready", 64'(ifu_req_ready & lsu_req_ready), 64'd0);
    own = lsu_req_ready;
    if (own) begin
      a = lsu_addr; w = lsu_wen; wd = lsu_wdata; m = lsu_wen ? lsu_wmask : 8'h00;
    end else begin
      a = ifu_addr; w = 1'b0; wd = 32'd0; m = 8'h00;
    end
    idx = int'(a[5:2]);
    tick();
    if (own) lsu_req_valid = 1'b0;
    else     ifu_req_valid = 1'b0;
    for (int k = 0; k <= stall; k++) begin
      #1;
      chk("issue_valid", 64'(mem_req_valid), 64'd1);
      chk("issue_addr", 64'(mem_addr), 64'(a));
      chk("issue_wen", 64'(mem_wen), 64'(w));
      chk("issue_wmask", 64'(mem_wmask), 64'(m));
      if (w) chk("issue_wdata", 64'(mem_wdata), 64'(wd));
      chk("issue_no_ready", 64'(ifu_req_ready | lsu_req_ready), 64'd0);
      mem_req_ready = (k == stall);
      tick();
    end
    mem_req_ready = 1'b0;
    #1;
    chk("wait_no_req", 64'(mem_req_valid), 64'd0);
    chk("wait_no_resp", 64'(ifu_resp_valid | lsu_resp_valid), 64'd0);
    expd = w ? 32'd0 : refm[idx];
    if (w) begin
      for (int b = 0; b < 4; b++) if (m[b]) refm[idx][8*b +: 8] = wd[8*b +: 8];
    end
    tick();
    #1;
    chk("resp_owner", 64'({ifu_resp_valid, lsu_resp_valid}), own ? 64'd1 : 64'd2);
    chk("resp_data", 64'(own ? lsu_rdata : ifu_rdata), 64'(expd));
    tick();
    chk("resp_one_cycle", 64'(ifu_resp_valid | lsu_resp_valid), 64'd0);
  endtask

  // Round-robin reference: single requester wins, a tie goes opposite to the previous grant.
  task automatic serve_exp(input int stall);
    logic expo;
    logic own;
    expo = (ifu_req_valid && lsu_req_valid) ? ~model_last : lsu_req_valid;
    serve(stall, own);
    chk("grant_owner", 64'(own), 64'(expo));
    model_last = expo;
    if (expo) n_lsu++;
    else      n_ifu++;
  endtask

  initial begin
    rst = 1'b0;
    ifu_req_valid = 1'b0; ifu_addr = 32'd0;
    lsu_req_valid = 1'b0; lsu_addr = 32'd0; lsu_wen = 1'b0; lsu_wdata = 32'd0; lsu_wmask = 8'h00;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'd0;
    resp_en = 1'b1; late_resp = 1'b0; model_last = 1'b1;
    for (int i = 0; i < 16; i++) begin
      phys[i] = $urandom;
      refm[i] = phys[i];
    end
    phys[0] = 32'h0010_0073;
    refm[0] = 32'h0010_0073;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_resp_valid", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
    chk("rst_rdata", 64'({ifu_rdata, lsu_rdata}), 64'd0);
    rst = 1'b1;
    tick();

    // Tie straight out of reset: IFU first, then the still-pending LSU.
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0008; lsu_wen = 1'b0;
    serve_exp(0);
    serve_exp(0);

    // Continuous dual requests alternate I, L, I, L.
    for (int k = 0; k < 4; k++) begin
      if (!ifu_req_valid) begin ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000 | 32'(4 * k); end
      if (!lsu_req_valid) begin lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0020 | 32'(4 * k); lsu_wen = 1'b0; end
      chk("alternate_model", 64'(model_last), 64'(k[0] ? 1'b0 : 1'b1));
      serve_exp(0);
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    tick();

    // IFU boot fetch with zero-wait memory; serve checks the 3-cycle latency.
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    serve_exp(0);
    chk("ifu_boot_data_hold", 64'(ifu_rdata), 64'h0010_0073);

    // LSU write with a 5-cycle memory stall while IFU waits.
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010;
    serve_exp(5);
    serve_exp(0);
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b0;
    serve_exp(0);
    chk("lsu_readback", 64'(lsu_rdata), 64'hDEAD_BEEF);

    // Reset during WAIT drops the transaction; a late response is ignored.
    resp_en = 1'b0;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0014;
    #1;
    chk("pre_rst_grant", 64'(ifu_req_ready), 64'd1);
    tick();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_wait_req", 64'(mem_req_valid), 64'd0);
    chk("rst_wait_fields", 64'({mem_wen, mem_wmask, mem_addr}), 64'd0);
    chk("rst_wait_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_wait_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
    chk("rst_wait_rdata", 64'({ifu_rdata, lsu_rdata}), 64'd0);
    tick();
    rst = 1'b1;
    model_last = 1'b1;
    n_ifu = 0;
    n_lsu = 0;
    late_resp = 1'b1;
    tick();
    late_resp = 1'b0;
    resp_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("late_resp_ignored", 64'({ifu_resp_valid, lsu_resp_valid, mem_req_valid}), 64'd0);
      tick();
    end
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0018;
    serve_exp(0);

    // Randomized mixed traffic.
    for (int it = 0; it < 30; it++) begin
      if (!ifu_req_valid && ($urandom_range(0, 1) == 1)) begin
        ifu_req_valid = 1'b1;
        ifu_addr = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
      end
      if (!lsu_req_valid && (($urandom_range(0, 1) == 1) || !ifu_req_valid)) begin
        lsu_req_valid = 1'b1;
        lsu_addr  = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
        lsu_wen   = 1'($urandom_range(0, 1));
        lsu_wdata = $urandom;
        lsu_wmask = 8'($urandom);
      end
      serve_exp($urandom_range(0, 2));
    end

`ifdef MEM_ARB_PERF_EN
    chk("perf_ifu", 64'(perf_ifu_cnt), 64'(n_ifu));
    chk("perf_lsu", 64'(perf_lsu_cnt), 64'(n_lsu));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported physical memory (pmem DPI access path) between the instruction-fetch requester (IFU) and the load/store requester (LSU).
- Accepts one request at a time, sequences it onto the memory port with a valid/ready handshake, waits for the response, then returns data to the owning requester.
- Ties are broken round-robin. Sits between the core datapath (fetch/LSU) and the memory wrapper.

Parameters:
- ADDR_W, 32, address width of all address ports
- DATA_W, 32, data width of all data ports

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; asynchronous, active-low
- ifu_req_valid  input  1  IFU read request
- ifu_req_ready  output  1  IFU request accepted this cycle
- ifu_addr  input  ADDR_W  IFU read address
- ifu_resp_valid  output  1  one-cycle pulse; ifu_rdata valid
- ifu_rdata  output  DATA_W  IFU read data
- lsu_req_valid  input  1  LSU request
- lsu_req_ready  output  1  LSU request accepted this cycle
- lsu_addr  input  ADDR_W  LSU address
- lsu_wen  input  1  1 = write, 0 = read
- lsu_wdata  input  DATA_W  write data
- lsu_wmask  input  8  byte write mask
- lsu_resp_valid  output  1  one-cycle pulse; read data or write ack
- lsu_rdata  output  DATA_W  LSU read data (0 for writes)
- mem_req_valid  output  1  request to memory
- mem_req_ready  input  1  memory accepts request
- mem_addr  output  ADDR_W  latched address
- mem_wen  output  1  latched write enable
- mem_wdata  output  DATA_W  latched write data
- mem_wmask  output  8  latched mask (0 for IFU and reads)
- mem_resp_valid  input  1  memory response strobe
- mem_rdata  input  DATA_W  memory read data, valid with mem_resp_valid

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Plus a last_grant register (0 = IFU, 1 = LSU).
- Reset (rst = 0, asynchronous):
  - state = IDLE, last_grant = LSU, so the first tie goes to IFU.
  - All outputs 0; latched address, data and mask registers cleared.
  - An in-flight transaction is dropped; no response is ever issued for it. A late mem_resp_valid after reset is ignored.
- IDLE:
  - Only one requester valid: that requester is granted.
  - Both valid: grant the requester opposite to last_grant.
  - Grant: the granted requester's req_ready = 1 combinationally in IDLE only. On that edge, latch addr/wen/wdata/wmask and the owner id, update last_grant, and go to ISSUE.
  - No requests: stay in IDLE.
- ISSUE:
  - mem_req_valid = 1, and the mem_* fields hold the latched values.
  - mem_req_ready = 1: go to WAIT. Otherwise stay in ISSUE with the fields held stable.
- WAIT:
  - mem_req_valid = 0.
  - On mem_resp_valid = 1: latch mem_rdata (0 if the transaction is a write) and go to RESP.
- RESP:
  - The owner's resp_valid = 1 for exactly one cycle with the latched data; the other requester's resp_valid = 0.
  - Then go to IDLE.
- Both req_ready are 0 outside IDLE.
- Latency with zero-wait memory (mem_req_ready tied 1, response one cycle after accept):
  - accept at cycle 0, ISSUE at 1, WAIT at 2, RESP at 3.
  - Minimum turnaround is 4 cycles per transaction.
- Requester rule: req_valid and its fields must stay stable until req_ready. The arbiter does not check this.
- mem_resp_valid in IDLE, ISSUE or RESP is ignored. Memory must not respond in the same cycle it accepts.
- rdata outputs hold their last value between pulses; consumers must qualify with resp_valid.
- An IFU request is always a read: mem_wen = 0, mem_wmask = 0.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, adds outputs perf_ifu_cnt, perf_lsu_cnt and perf_stall_cnt (all 32 bits).
  - perf_ifu_cnt and perf_lsu_cnt increment per granted request.
  - perf_stall_cnt increments each cycle where any req_valid = 1 and no req_ready = 1.
  - All counters reset to 0 and saturate at 0xFFFFFFFF.
- When undefined, these ports and their logic are absent; arbitration behaviour is identical in both cases.

Test Plan:
- IFU read only, addr 0x80000000, mem returns 0x00100073 one cycle after accept -> ifu_req_ready at cycle 0, ifu_resp_valid at cycle 3 with ifu_rdata = 0x00100073; lsu_resp_valid stays 0.
- IFU and LSU both valid from reset -> IFU granted first, LSU granted in the next IDLE. Continuous dual requests then alternate IFU, LSU, IFU, LSU.
- LSU write, addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F -> mem_wen = 1, mem_wmask = 0x0F and mem_wdata = 0xDEADBEEF held through ISSUE; lsu_resp_valid pulses with lsu_rdata = 0.
- mem_req_ready held 0 for 5 cycles -> mem_req_valid held with stable fields for 5 cycles; no req_ready is asserted during the stall.
- rst driven low during WAIT -> all outputs 0 immediately. A later mem_resp_valid produces no resp_valid, and the next request is accepted normally.
- MEM_ARB_PERF_EN defined: 3 IFU grants, 2 LSU grants, 4 stalled cycles -> perf_ifu_cnt = 3, perf_lsu_cnt = 2, perf_stall_cnt = 4.
